score_controller: RTL

//   Owns the in-game score: a NUM_DIGITS BCD run counter, a high-score register and the

---
 rtl/score_controller_pkg.sv | 13 +
 rtl/score_controller_if.sv | 30 +++
 rtl/score_controller_render.sv | 57 +++++
 rtl/score_controller.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/score_controller_pkg.sv
// Shared definitions for the score controller: game state encoding and BCD digit constants.
package score_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/score_controller_if.sv
// Game-event, scan-position and score-output bundle between the game logic and the score controller.
interface score_controller_if
    import score_controller_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CONV       = 0
);
    logic                           start;
    logic                           over;
    logic                           inc;
    logic                           frame;
    logic                           show_hi;
    logic [9-CONV:0]                hpos;
    logic [9-CONV:0]                vpos;
    logic                           score_color;
    logic [NIBBLE_W*NUM_DIGITS-1:0] score;
    logic [NIBBLE_W*NUM_DIGITS-1:0] hi_score;
    logic                           running;
    logic                           new_hi;

    modport master (
        output start, over, inc, frame, show_hi, hpos, vpos,
        input  score_color, score, hi_score, running, new_hi
    );

    modport slave (
        input  start, over, inc, frame, show_hi, hpos, vpos,
        output score_color, score, hi_score, running, new_hi
    );
endinterface

// File: rtl/score_controller_render.sv
// Single 4-wide digit glyph with a registered pixel output; row 0 and row 6 are blank spacing.
module score_render
    import score_controller_pkg::*;
#(
    parameter int W      = 10,
    parameter int OFFSET = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        lx,
    input  logic [W-1:0]        ly,
    input  logic [NIBBLE_W-1:0] num,
    output logic                px
);
    logic [19:0]         font;
    logic [W-1:0]        row;
    logic [NIBBLE_W-1:0] nib;
    logic                lit;

    // Five 4-bit rows per digit, first drawn row in the top nibble, leftmost column in the MSB.
    always_comb begin
        case (num)
            4'd0:    font = 20'hF999F;
            4'd1:    font = 20'h26227;
            4'd2:    font = 20'hF1F8F;
            4'd3:    font = 20'hF171F;
            4'd4:    font = 20'h99F11;
            4'd5:    font = 20'hF8F1F;
            4'd6:    font = 20'hF8F9F;
            4'd7:    font = 20'hF1244;
            4'd8:    font = 20'hF9F9F;
            4'd9:    font = 20'hF9F1F;
            default: font = 20'h0;
        endcase
        row = ly - W'(1 + OFFSET);
        case (row[2:0])
            3'd1:    nib = font[19:16];
            3'd2:    nib = font[15:12];
            3'd3:    nib = font[11:8];
            3'd4:    nib = font[7:4];
            3'd5:    nib = font[3:0];
            default: nib = '0;
        endcase
        lit = 1'b0;
        if (lx < W'(4) && row >= W'(1) && row <= W'(5)) begin
            lit = nib[~lx[1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px <= 1'b0;
        end else begin
            px <= lit;
        end
    end
endmodule

// File: rtl/score_controller.sv
// Run score, high score and game state; time-multiplexes one glyph across the digit field.
//   state | meaning
//   IDLE  | after reset, no game yet; score renders as zeros
//   RUN   | game in progress, i_inc pulses count
//   OVER  | game ended; high score updated, blinking if a new high was set
module score_controller
    import score_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CONV         = 0,
    parameter int X_ORIGIN     = 560,
    parameter int Y_ORIGIN     = 8,
    parameter int PITCH_LOG2   = 3,
    parameter int BLINK_FRAMES = 16
) (
    input logic               clk,
    input logic               rst,
    score_controller_if.slave bus
);
    localparam int W     = 10 - CONV;
    localparam int SW    = NIBBLE_W * NUM_DIGITS;
    localparam int FIELD = NUM_DIGITS << PITCH_LOG2;
    localparam int CW    = $clog2(BLINK_FRAMES) + 1;

    state_t          state_q, state_d;
    logic [SW-1:0]   score_q, score_d, hi_q, hi_d, inc_val;
    logic            new_hi_q, new_hi_d, blank_q, blank_d, saturated;
    logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
    logic [NUM_DIGITS:0] carry;

    assign carry[0] = 1'b1;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_bcd_inc
        logic [NIBBLE_W-1:0] dig;
        assign dig          = score_q[g*NIBBLE_W +: NIBBLE_W];
        assign carry[g+1]   = carry[g] && (dig == BCD_MAX);
        assign inc_val[g*NIBBLE_W +: NIBBLE_W] =
            !carry[g] ? dig : (dig == BCD_MAX) ? '0 : dig + 1'b1;
    end
    assign saturated = carry[NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            score_q     <= '0;
            hi_q        <= '0;
            new_hi_q    <= 1'b0;
            blank_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            hi_q        <= hi_d;
            new_hi_q    <= new_hi_d;
            blank_q     <= blank_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        hi_d        = hi_q;
        new_hi_d    = new_hi_q;
        blank_d     = blank_q;
        blink_cnt_d = blink_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    score_d = '0;
                end
            end
            RUN: begin
                if (bus.start) begin
                    score_d = '0;
                end else begin
                    if (bus.inc && !saturated) score_d = inc_val;
                    if (bus.over) begin
                        state_d = OVER;
                        // Packed BCD orders the same as binary, MSD first.
                        if (score_d > hi_q) begin
                            hi_d     = score_d;
                            new_hi_d = 1'b1;
                        end
                    end
                end
            end
            OVER: begin
                if (bus.start) begin
                    state_d     = RUN;
                    score_d     = '0;
                    new_hi_d    = 1'b0;
                    blank_d     = 1'b0;
                    blink_cnt_d = '0;
                end else if (new_hi_q && bus.frame) begin
                    if (blink_cnt_q == CW'(BLINK_FRAMES - 1)) begin
                        blank_d     = !blank_q;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [W-1:0]        rel, lx_q, ly_q;
    logic [SW-1:0]       sel_val;
    logic [NIBBLE_W-1:0] num_sel, num_q;
    logic                glyph_px;

    always_comb begin
        rel     = bus.hpos - W'(X_ORIGIN);
        sel_val = (state_q == IDLE) ? '0 : (bus.show_hi ? hi_q : score_q);
        num_sel = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if ((rel >> PITCH_LOG2) == W'(d)) begin
                num_sel = sel_val[(NUM_DIGITS-1-d)*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    // All-ones lx lies beyond the glyph width, so out-of-field pixels stay dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q <= '0;
            lx_q  <= '1;
            ly_q  <= '0;
        end else if (rel < W'(FIELD)) begin
            num_q <= num_sel;
            lx_q  <= rel & W'((1 << PITCH_LOG2) - 1);
            ly_q  <= bus.vpos - W'(Y_ORIGIN) + W'(1);
        end else begin
            lx_q  <= '1;
        end
    end

    score_render #(.W(W), .OFFSET(0)) u_render (
        .clk (clk),
        .rst (rst),
        .lx  (lx_q),
        .ly  (ly_q),
        .num (num_q),
        .px  (glyph_px)
    );

    assign bus.score_color = glyph_px && !blank_q;
    assign bus.score       = score_q;
    assign bus.hi_score    = hi_q;
    assign bus.running     = (state_q == RUN);
    assign bus.new_hi      = new_hi_q;
endmodule
